wb_arbiter: RTL and testbench

Writeback arbiter between the execute units and the shared result bus (CDB) that feeds the ROB writeback port and the dispatch-stage bypass. It buffers ALU and load results in small per-source FIFOs and grants one result per cycle. Loads get priority, with a starvation guard for the ALU. The whole block is flushed on fetch redirect.

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_arbiter_if.sv | 52 +++++
 rtl/wb_arbiter_fifo.sv | 71 +++++++
 rtl/wb_arbiter.sv | 127 ++++++++++++
 tb/tb_wb_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the writeback arbiter and its result FIFOs.
// The widths mirror the core-wide values used by the ROB and dispatch stage.
package wb_arbiter_pkg;

  localparam int ROB_ID_WIDTH   = 6;
  localparam int REG_DATA_WIDTH = 32;
  localparam int ADDR_WIDTH     = 32;

  // One writeback result as it travels through a source FIFO onto the CDB.
  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0]   rob_id;
    logic [REG_DATA_WIDTH-1:0] reg_data;
    logic                      npc_valid;
    logic                      npc_mispred;
    logic [ADDR_WIDTH-1:0]     npc;
  } wb_pkt_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the execute-unit writeback handshakes, the flush line and the
// result bus (CDB). The arbiter takes the slave side; producers and
// consumers (or a bench) take the master side.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic                      flush;

  logic                      alu_wb_valid;
  logic                      alu_wb_ready;
  logic [ROB_ID_WIDTH-1:0]   alu_wb_rob_id;
  logic [REG_DATA_WIDTH-1:0] alu_wb_reg_data;
  logic                      alu_wb_npc_valid;
  logic                      alu_wb_npc_mispred;
  logic [ADDR_WIDTH-1:0]     alu_wb_npc;

  logic                      ld_wb_valid;
  logic                      ld_wb_ready;
  logic [ROB_ID_WIDTH-1:0]   ld_wb_rob_id;
  logic [REG_DATA_WIDTH-1:0] ld_wb_reg_data;

  logic                      cdb_valid;
  logic                      cdb_src;
  logic [ROB_ID_WIDTH-1:0]   cdb_rob_id;
  logic [REG_DATA_WIDTH-1:0] cdb_reg_data;
  logic                      cdb_npc_valid;
  logic                      cdb_npc_mispred;
  logic [ADDR_WIDTH-1:0]     cdb_npc;

  modport slave (
    input  flush,
    input  alu_wb_valid, alu_wb_rob_id, alu_wb_reg_data,
           alu_wb_npc_valid, alu_wb_npc_mispred, alu_wb_npc,
    output alu_wb_ready,
    input  ld_wb_valid, ld_wb_rob_id, ld_wb_reg_data,
    output ld_wb_ready,
    output cdb_valid, cdb_src, cdb_rob_id, cdb_reg_data,
           cdb_npc_valid, cdb_npc_mispred, cdb_npc
  );

  modport master (
    output flush,
    output alu_wb_valid, alu_wb_rob_id, alu_wb_reg_data,
           alu_wb_npc_valid, alu_wb_npc_mispred, alu_wb_npc,
    input  alu_wb_ready,
    output ld_wb_valid, ld_wb_rob_id, ld_wb_reg_data,
    input  ld_wb_ready,
    input  cdb_valid, cdb_src, cdb_rob_id, cdb_reg_data,
           cdb_npc_valid, cdb_npc_mispred, cdb_npc
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: small circular buffer holding writeback results for one source.
// Pointers are log2(DEPTH) bits and wrap on their own; the occupancy count
// carries one extra bit so full and empty are distinguishable. Flush empties
// the buffer and blocks any push or pop in the same cycle.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type pkt_t = wb_pkt_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  pkt_t push_pkt,
  input  logic pop,
  output pkt_t head_pkt,
  output logic empty,
  output logic full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en, rd_en;
  pkt_t          mem_q [DEPTH];

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign wr_en    = push && !full && !flush;
  assign rd_en    = pop && !empty && !flush;
  assign head_pkt = mem_q[rd_q];

  // Next pointer/count state; flush snaps everything back to empty.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_en) wr_d = wr_q + PW'(1);
      if (rd_en) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage; contents are only meaningful behind a non-empty count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_pkt;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU and load results in per-source FIFOs and
// grants one result per cycle onto the CDB. Loads win contention unless the
// ALU has waited through STARVE_LIMIT consecutive load grants. The CDB
// outputs depend only on FIFO heads, starve_q and flush, never on the
// incoming writeback ports.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);

  localparam int             SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STARVE_MAX) ? v : v + SW'(1);
  endfunction

  wb_pkt_t       alu_in, ld_in, alu_head, ld_head;
  logic          alu_empty, alu_full, ld_empty, ld_full;
  logic          alu_push, ld_push;
  logic          grant_alu, grant_ld;
  logic [SW-1:0] starve_q, starve_d;

  // Ready reflects the count at the start of the cycle, so a full FIFO
  // stays not-ready even in the cycle it is being popped.
  assign bus.alu_wb_ready = !alu_full;
  assign bus.ld_wb_ready  = !ld_full;
  assign alu_push = bus.alu_wb_valid && !alu_full && !bus.flush;
  assign ld_push  = bus.ld_wb_valid  && !ld_full  && !bus.flush;

  assign alu_in = '{rob_id:      bus.alu_wb_rob_id,
                    reg_data:    bus.alu_wb_reg_data,
                    npc_valid:   bus.alu_wb_npc_valid,
                    npc_mispred: bus.alu_wb_npc_mispred,
                    npc:         bus.alu_wb_npc};

  // Loads never carry a next-PC.
  assign ld_in = '{rob_id:      bus.ld_wb_rob_id,
                   reg_data:    bus.ld_wb_reg_data,
                   npc_valid:   1'b0,
                   npc_mispred: 1'b0,
                   npc:         '0};

  wb_fifo #(.DEPTH(BUF_DEPTH), .pkt_t(wb_pkt_t)) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .push     (alu_push),
    .push_pkt (alu_in),
    .pop      (grant_alu),
    .head_pkt (alu_head),
    .empty    (alu_empty),
    .full     (alu_full)
  );

  wb_fifo #(.DEPTH(BUF_DEPTH), .pkt_t(wb_pkt_t)) u_ld_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .push     (ld_push),
    .push_pkt (ld_in),
    .pop      (grant_ld),
    .head_pkt (ld_head),
    .empty    (ld_empty),
    .full     (ld_full)
  );

  // Grant: load first, ALU when alone or when it has been starved too long.
  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (!bus.flush) begin
      if (!ld_empty && (alu_empty || starve_q != STARVE_MAX)) begin
        grant_ld = 1'b1;
      end else if (!alu_empty) begin
        grant_alu = 1'b1;
      end
    end
  end

  // Starvation counter next state: counts load wins over a waiting ALU.
  always_comb begin
    starve_d = starve_q;
    if (bus.flush || alu_empty || grant_alu) begin
      starve_d = '0;
    end else if (grant_ld) begin
      starve_d = sat_inc(starve_q);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  // CDB drive from the winning head; all fields zero when idle.
  always_comb begin
    bus.cdb_valid       = 1'b0;
    bus.cdb_src         = 1'b0;
    bus.cdb_rob_id      = '0;
    bus.cdb_reg_data    = '0;
    bus.cdb_npc_valid   = 1'b0;
    bus.cdb_npc_mispred = 1'b0;
    bus.cdb_npc         = '0;
    if (grant_alu) begin
      bus.cdb_valid       = 1'b1;
      bus.cdb_rob_id      = alu_head.rob_id;
      bus.cdb_reg_data    = alu_head.reg_data;
      bus.cdb_npc_valid   = alu_head.npc_valid;
      bus.cdb_npc_mispred = alu_head.npc_mispred;
      bus.cdb_npc         = alu_head.npc;
    end else if (grant_ld) begin
      bus.cdb_valid    = 1'b1;
      bus.cdb_src      = 1'b1;
      bus.cdb_rob_id   = ld_head.rob_id;
      bus.cdb_reg_data = ld_head.reg_data;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus queues feed the two writeback
// ports, hand-ordered expected CDB results sit in a scoreboard queue, and a
// negedge monitor pops and compares every CDB result.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  typedef struct packed {
    logic    src;
    wb_pkt_t pkt;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;
  logic alu_en, ld_en;

  wb_pkt_t alu_q[$];
  wb_pkt_t ld_q[$];
  exp_t    exp_q[$];
  exp_t    mon_e, mon_a;
  wb_pkt_t drop;

  wb_arbiter_if bus ();

  wb_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests_run++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic wb_pkt_t mk_alu(input int rob, input logic [31:0] data,
                                     input logic nv, input logic nm, input logic [31:0] npc);
    return '{rob_id: ROB_ID_WIDTH'(rob), reg_data: data, npc_valid: nv,
             npc_mispred: nm, npc: npc};
  endfunction

  function automatic wb_pkt_t mk_ld(input int rob);
    return '{rob_id: ROB_ID_WIDTH'(rob), reg_data: 32'hA000 + 32'(rob),
             npc_valid: 1'b0, npc_mispred: 1'b0, npc: '0};
  endfunction

  function automatic exp_t ex(input logic src, input wb_pkt_t p);
    return '{src: src, pkt: p};
  endfunction

  // One clock: offer queue heads, retire what the DUT accepts, advance.
  task automatic cyc();
    bus.alu_wb_valid = alu_en && (alu_q.size() > 0);
    if (bus.alu_wb_valid) begin
      bus.alu_wb_rob_id      = alu_q[0].rob_id;
      bus.alu_wb_reg_data    = alu_q[0].reg_data;
      bus.alu_wb_npc_valid   = alu_q[0].npc_valid;
      bus.alu_wb_npc_mispred = alu_q[0].npc_mispred;
      bus.alu_wb_npc         = alu_q[0].npc;
    end else begin
      bus.alu_wb_rob_id      = '0;
      bus.alu_wb_reg_data    = '0;
      bus.alu_wb_npc_valid   = 1'b0;
      bus.alu_wb_npc_mispred = 1'b0;
      bus.alu_wb_npc         = '0;
    end
    bus.ld_wb_valid = ld_en && (ld_q.size() > 0);
    if (bus.ld_wb_valid) begin
      bus.ld_wb_rob_id   = ld_q[0].rob_id;
      bus.ld_wb_reg_data = ld_q[0].reg_data;
    end else begin
      bus.ld_wb_rob_id   = '0;
      bus.ld_wb_reg_data = '0;
    end
    #1;
    if (bus.alu_wb_valid && bus.alu_wb_ready && !bus.flush && !rst) drop = alu_q.pop_front();
    if (bus.ld_wb_valid && bus.ld_wb_ready && !bus.flush && !rst) drop = ld_q.pop_front();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every CDB result must match the next expected one.
  always @(negedge clk) begin
    if (!rst && bus.cdb_valid) begin
      mon_a = {bus.cdb_src, bus.cdb_rob_id, bus.cdb_reg_data,
               bus.cdb_npc_valid, bus.cdb_npc_mispred, bus.cdb_npc};
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL cdb_unexpected: got src=%0d rob=%0d, required no result",
                 bus.cdb_src, bus.cdb_rob_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("cdb_pkt", 128'(mon_a), 128'(mon_e));
      end
      if (bus.cdb_src) begin
        check("ld_npc_zero", 128'({bus.cdb_npc_valid, bus.cdb_npc_mispred, bus.cdb_npc}), 128'(0));
      end
    end
  end

  initial begin
    tests_run = 0;
    fails     = 0;
    alu_en    = 1'b1;
    ld_en     = 1'b1;
    rst       = 1'b1;
    bus.flush = 1'b0;
    bus.alu_wb_valid = 1'b0; bus.alu_wb_rob_id = '0; bus.alu_wb_reg_data = '0;
    bus.alu_wb_npc_valid = 1'b0; bus.alu_wb_npc_mispred = 1'b0; bus.alu_wb_npc = '0;
    bus.ld_wb_valid = 1'b0; bus.ld_wb_rob_id = '0; bus.ld_wb_reg_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_alu_ready", 128'(bus.alu_wb_ready), 128'(1));
    check("rst_ld_ready",  128'(bus.ld_wb_ready),  128'(1));
    check("rst_cdb_valid", 128'(bus.cdb_valid),    128'(0));
    check("rst_cdb_fields", 128'({bus.cdb_src, bus.cdb_rob_id, bus.cdb_reg_data,
          bus.cdb_npc_valid, bus.cdb_npc_mispred, bus.cdb_npc}), 128'(0));
    rst = 1'b0;

    // Single ALU result: visible the cycle after acceptance, then gone
    alu_q.push_back(mk_alu(5, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h100));
    exp_q.push_back(ex(1'b0, mk_alu(5, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h100)));
    cyc();
    check("t1_latency_valid", 128'(bus.cdb_valid), 128'(1));
    cyc();
    check("t1_idle_after", 128'(bus.cdb_valid), 128'(0));

    // Contention with STARVE_LIMIT 3: ld3 ld4 ld5 alu1 ld6 alu2
    alu_q.push_back(mk_alu(1, 32'h1111, 1'b1, 1'b0, 32'h200));
    alu_q.push_back(mk_alu(2, 32'h2222, 1'b0, 1'b0, 32'h0));
    for (int r = 3; r <= 6; r++) ld_q.push_back(mk_ld(r));
    exp_q.push_back(ex(1'b1, mk_ld(3)));
    exp_q.push_back(ex(1'b1, mk_ld(4)));
    exp_q.push_back(ex(1'b1, mk_ld(5)));
    exp_q.push_back(ex(1'b0, mk_alu(1, 32'h1111, 1'b1, 1'b0, 32'h200)));
    exp_q.push_back(ex(1'b1, mk_ld(6)));
    exp_q.push_back(ex(1'b0, mk_alu(2, 32'h2222, 1'b0, 1'b0, 32'h0)));
    repeat (8) cyc();
    check("t2_drained", 128'(exp_q.size()), 128'(0));

    // Fill: ALU FIFO fills behind a load stream; order x y z a w b c
    alu_q.push_back(mk_alu(7, 32'h7777, 1'b0, 1'b0, 32'h0));
    alu_q.push_back(mk_alu(8, 32'h8888, 1'b1, 1'b0, 32'h300));
    alu_q.push_back(mk_alu(9, 32'h9999, 1'b1, 1'b1, 32'h400));
    for (int r = 10; r <= 13; r++) ld_q.push_back(mk_ld(r));
    exp_q.push_back(ex(1'b1, mk_ld(10)));
    exp_q.push_back(ex(1'b1, mk_ld(11)));
    exp_q.push_back(ex(1'b1, mk_ld(12)));
    exp_q.push_back(ex(1'b0, mk_alu(7, 32'h7777, 1'b0, 1'b0, 32'h0)));
    exp_q.push_back(ex(1'b1, mk_ld(13)));
    exp_q.push_back(ex(1'b0, mk_alu(8, 32'h8888, 1'b1, 1'b0, 32'h300)));
    exp_q.push_back(ex(1'b0, mk_alu(9, 32'h9999, 1'b1, 1'b1, 32'h400)));
    cyc();
    cyc();
    check("t3_full_c2", 128'(bus.alu_wb_ready), 128'(0));
    cyc();
    check("t3_full_c3", 128'(bus.alu_wb_ready), 128'(0));
    cyc();
    check("t3_full_in_pop_cycle", 128'(bus.alu_wb_ready), 128'(0));
    check("t3_alu_pop_src", 128'({bus.cdb_valid, bus.cdb_src}), 128'(2'b10));
    cyc();
    check("t3_ready_back", 128'(bus.alu_wb_ready), 128'(1));
    check("t3_third_waiting", 128'(alu_q.size()), 128'(1));
    repeat (3) cyc();
    check("t3_third_taken", 128'(alu_q.size()), 128'(0));
    check("t3_drained", 128'(exp_q.size()), 128'(0));

    // Flush with both FIFOs occupied and a load push coincident
    alu_q.push_back(mk_alu(50, 32'h5050, 1'b0, 1'b0, 32'h0));
    alu_q.push_back(mk_alu(51, 32'h5151, 1'b0, 1'b0, 32'h0));
    for (int r = 52; r <= 54; r++) ld_q.push_back(mk_ld(r));
    exp_q.push_back(ex(1'b1, mk_ld(52)));
    cyc();
    cyc();
    check("t4_pre_alu_full", 128'(bus.alu_wb_ready), 128'(0));
    bus.flush = 1'b1;
    #1;
    check("t4_flush_cycle_valid", 128'(bus.cdb_valid), 128'(0));
    cyc();
    bus.flush = 1'b0;
    alu_q.delete();
    ld_q.delete();
    #1;
    check("t4_post_alu_ready", 128'(bus.alu_wb_ready), 128'(1));
    check("t4_post_ld_ready",  128'(bus.ld_wb_ready),  128'(1));
    check("t4_post_valid",     128'(bus.cdb_valid),    128'(0));
    repeat (3) cyc();
    check("t4_drained", 128'(exp_q.size()), 128'(0));

    // Wrap-around: 10 loads with gaps, order must be preserved
    for (int r = 60; r <= 69; r++) begin
      ld_q.push_back(mk_ld(r));
      exp_q.push_back(ex(1'b1, mk_ld(r)));
    end
    for (int i = 0; i < 20; i++) begin
      ld_en = (i % 3 != 2);
      cyc();
    end
    ld_en = 1'b1;
    repeat (2) cyc();
    check("t5_all_pushed", 128'(ld_q.size()), 128'(0));
    check("t5_drained", 128'(exp_q.size()), 128'(0));

    // Reset mid-burst discards buffered results
    alu_q.push_back(mk_alu(70, 32'h7070, 1'b0, 1'b0, 32'h0));
    ld_q.push_back(mk_ld(71));
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("t6_alu_ready", 128'(bus.alu_wb_ready), 128'(1));
    check("t6_ld_ready",  128'(bus.ld_wb_ready),  128'(1));
    check("t6_valid",     128'(bus.cdb_valid),    128'(0));
    repeat (3) cyc();
    check("t6_nothing_left", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
